// File: rtl/four_bit_pkg.sv
// Shared constants for the four_bit ripple-carry adder.
// Holds the default operand width and the reset value of the registered result.
package four_bit_pkg;

    localparam int   WIDTH_DEF = 4;
    localparam logic RST_VAL   = 1'b0;

    // Registered result bundle, loaded as one unit so the three outputs never skew.
    typedef struct packed {
        logic [WIDTH_DEF-1:0] sum;
        logic                 carry;
        logic                 ovf;
    } result_t;

endpackage

// File: rtl/four_bit_full_adder.sv
// One-bit full adder cell for the ripple chain.
// Latency: purely combinational, zero cycles.
// Backpressure: none, the cell has no flow control.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic halfSum;

    assign halfSum = a ^ b;
    assign s       = halfSum ^ cin;
    assign cout    = (a & b) | (cin & halfSum);

endmodule

// File: rtl/four_bit.sv
// Ripple-carry adder with combinational sum/carry/overflow plus a registered copy.
// Latency: sum, carryOut, ovf are zero-cycle; sum_q, carry_q, ovf_q lag by one clk.
// Backpressure: none, a new result is accepted every cycle.
module four_bit
    import four_bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             carryIn,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut,
    input  logic             clk,
    input  logic             rst,
    output logic             ovf,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q,
    output logic             ovf_q
);

    // carryChain[i] is the carry into bit i; carryChain[WIDTH] leaves the MSB.
    logic [WIDTH:0] carryChain;

    assign carryChain[0] = carryIn;

    for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
        full_adder u_fa (
            .a    (inA[i]),
            .b    (inB[i]),
            .cin  (carryChain[i]),
            .s    (sum[i]),
            .cout (carryChain[i+1])
        );
    end

    assign carryOut = carryChain[WIDTH];
    assign ovf      = carryChain[WIDTH-1] ^ carryChain[WIDTH];

    // Reset is checked first so it wins over the same-edge load.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= {WIDTH{RST_VAL}};
            carry_q <= RST_VAL;
            ovf_q   <= RST_VAL;
        end else begin
            sum_q   <= sum;
            carry_q <= carryOut;
            ovf_q   <= ovf;
        end
    end

endmodule

// File: tb/tb_four_bit.sv
// Directed and exhaustive checks of four_bit: combinational adder, registered stage, reset.
module tb_four_bit;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] inA;
    logic [W-1:0] inB;
    logic         carryIn;
    logic [W-1:0] sum;
    logic         carryOut;
    logic         ovf;
    logic [W-1:0] sum_q;
    logic         carry_q;
    logic         ovf_q;

    int passCnt  = 0;
    int totalCnt = 0;

    four_bit #(.WIDTH(W)) dut (
        .inA      (inA),
        .inB      (inB),
        .carryIn  (carryIn),
        .sum      (sum),
        .carryOut (carryOut),
        .clk      (clk),
        .rst      (rst),
        .ovf      (ovf),
        .sum_q    (sum_q),
        .carry_q  (carry_q),
        .ovf_q    (ovf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] expSum;
        logic         expCarry;
        logic         expOvf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        totalCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    initial begin
        // Hand-computed vectors: a, b, cin -> sum, carry, ovf
        vecs[0] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0};
        vecs[1] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0};
        vecs[2] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
        vecs[3] = '{4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1};
        vecs[4] = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1};
        vecs[5] = '{4'd5,  4'd3,  1'b0, 4'd8,  1'b0, 1'b1};
        vecs[6] = '{4'd12, 4'd12, 1'b0, 4'd8,  1'b1, 1'b0};
        vecs[7] = '{4'd6,  4'd5,  1'b1, 4'd12, 1'b0, 1'b1};
        vecs[8] = '{4'd2,  4'd3,  1'b1, 4'd6,  1'b0, 1'b0};
        vecs[9] = '{4'd9,  4'd9,  1'b1, 4'd3,  1'b1, 1'b1};

        rst = 1'b1; inA = '0; inB = '0; carryIn = 1'b0;
        @(posedge clk); #1;
        chk("reset sum_q",   int'(sum_q),   0);
        chk("reset carry_q", int'(carry_q), 0);
        chk("reset ovf_q",   int'(ovf_q),   0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            inA = vecs[i].a; inB = vecs[i].b; carryIn = vecs[i].cin;
            #1;
            chk($sformatf("vec%0d sum", i),      int'(sum),      int'(vecs[i].expSum));
            chk($sformatf("vec%0d carryOut", i), int'(carryOut), int'(vecs[i].expCarry));
            chk($sformatf("vec%0d ovf", i),      int'(ovf),      int'(vecs[i].expOvf));
            @(posedge clk); #1;
            chk($sformatf("vec%0d sum_q", i),   int'(sum_q),   int'(vecs[i].expSum));
            chk($sformatf("vec%0d carry_q", i), int'(carry_q), int'(vecs[i].expCarry));
            chk($sformatf("vec%0d ovf_q", i),   int'(ovf_q),   int'(vecs[i].expOvf));
            @(negedge clk);
        end

        // Last vector was 9+9+1: registered 3/1/1. Now reset with inputs held.
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst sum_q",        int'(sum_q),    0);
        chk("rst carry_q",      int'(carry_q),  0);
        chk("rst ovf_q",        int'(ovf_q),    0);
        chk("rst sum kept",     int'(sum),      3);
        chk("rst carryOut kept", int'(carryOut), 1);
        chk("rst ovf kept",     int'(ovf),      1);

        // Mid-cycle input change must not reach the register before the edge.
        @(negedge clk);
        rst = 1'b0; inA = 4'd4; inB = 4'd1; carryIn = 1'b0;
        @(posedge clk); #1;
        chk("load sum_q", int'(sum_q), 5);
        #2;
        inA = 4'd10; inB = 4'd10; carryIn = 1'b0;
        #1;
        chk("mid-cycle sum",     int'(sum),   4);
        chk("mid-cycle sum_q",   int'(sum_q), 5);
        chk("mid-cycle carry_q", int'(carry_q), 0);
        @(posedge clk); #1;
        chk("next-edge sum_q",   int'(sum_q),   4);
        chk("next-edge carry_q", int'(carry_q), 1);
        chk("next-edge ovf_q",   int'(ovf_q),   1);

        // Exhaustive sweep, one combination per 10 time units.
        for (int c = 0; c < 2; c++) begin
            for (int ab = 0; ab < 256; ab++) begin
                logic [W:0]   expTotal;
                logic [W-1:0] aV, bV;
                logic         expO;
                aV = ab[7:4]; bV = ab[3:0];
                inA = aV; inB = bV; carryIn = c[0];
                expTotal = {1'b0, aV} + {1'b0, bV} + {4'd0, c[0]};
                expO = (aV[W-1] == bV[W-1]) && (expTotal[W-1] != aV[W-1]);
                #9;
                chk($sformatf("sweep a=%0d b=%0d c=%0d total", aV, bV, c),
                    int'({carryOut, sum}), int'(expTotal));
                chk($sformatf("sweep a=%0d b=%0d c=%0d ovf", aV, bV, c),
                    int'(ovf), int'(expO));
                #1;
            end
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/four_bit.md
FOUR_BIT -- requirements
Module: four_bit

Interface
REQ-001 Parameter: WIDTH, default 4, operand and sum width; only 4 is required to be verified.
REQ-002 clk  input  1  rising-edge clock for the registered result stage only.
REQ-003 rst  input  1  reset, synchronous and active-high, as already decided for this block.
REQ-004 inA  input  WIDTH  unsigned operand A.
REQ-005 inB  input  WIDTH  unsigned operand B.
REQ-006 carryIn  input  1  carry into bit 0.
REQ-007 sum  output  WIDTH  combinational sum, low WIDTH bits of inA+inB+carryIn.
REQ-008 carryOut  output  1  combinational carry out of the MSB.
REQ-009 ovf  output  1  combinational two's-complement overflow flag.
REQ-010 sum_q  output  WIDTH  registered copy of sum.
REQ-011 carry_q  output  1  registered copy of carryOut.
REQ-012 ovf_q  output  1  registered copy of ovf.
REQ-013 Port declaration order SHALL be inA, inB, carryIn, sum, carryOut, clk, rst, ovf, sum_q, carry_q, ovf_q, so existing five-port positional instantiations remain valid; unconnected clk/rst SHALL NOT affect sum/carryOut.

Function
REQ-014 {carryOut, sum} SHALL equal inA + inB + carryIn, evaluated at WIDTH+1 bits, for all 2^(2*WIDTH+1) input combinations.
REQ-015 sum, carryOut and ovf SHALL be purely combinational with zero clock latency; no latch or clock dependency.
REQ-016 Adder SHALL be ripple-carry: bit i carry-in is bit i-1 carry-out; bit 0 carry-in is carryIn; carryOut is bit WIDTH-1 carry-out.
REQ-017 Per bit: s = a XOR b XOR c; cout = (a AND b) OR (c AND (a XOR b)).
REQ-018 ovf SHALL equal carry into MSB XOR carry out of MSB.
REQ-019 Wrap-around: when the true result exceeds 2^WIDTH-1, sum SHALL hold the low WIDTH bits and carryOut SHALL be 1.
REQ-020 On each rising clk edge with rst=0, sum_q, carry_q, ovf_q SHALL load the current sum, carryOut, ovf (latency one cycle).
REQ-021 Inputs changing between edges SHALL affect registered outputs only at the next edge.

Reset
REQ-022 On a rising clk edge with rst=1, sum_q, carry_q, ovf_q SHALL become 0.
REQ-023 rst SHALL NOT affect the combinational outputs sum, carryOut, ovf.
REQ-024 Reset SHALL take priority over the load of REQ-020 in the same edge.

Structure
REQ-025 A single sub-module full_adder (inputs a, b, cin; outputs s, cout) SHALL be instantiated WIDTH times via a generate loop.
REQ-026 WIDTH default and the registered-output reset value (0) SHALL be defined as constants in the shared package four_bit_pkg.
REQ-027 No other sub-modules; the registered stage lives in four_bit.

Verification
REQ-028 inA=0, inB=0, carryIn=0 -> sum=0, carryOut=0, ovf=0.
REQ-029 inA=15, inB=1, carryIn=0 -> sum=0, carryOut=1, ovf=0; inA=15, inB=15, carryIn=1 -> sum=15, carryOut=1.
REQ-030 inA=7, inB=1, carryIn=0 -> sum=8, carryOut=0, ovf=1; inA=8, inB=8, carryIn=0 -> sum=0, carryOut=1, ovf=1.
REQ-031 Exhaustive sweep: carryIn=0 then 1, {inA,inB} from 0 to 255, one combination per 10 time units -> every {carryOut,sum} equals the arithmetic sum, checked before each change.
REQ-032 inA=9, inB=9, carryIn=1, rst=0, one clock -> sum_q=3, carry_q=1; then rst=1 for one clock -> sum_q=0, carry_q=0, ovf_q=0 while sum stays 3.
